gpio_word_assembler: RTL and testbench
======================================

Name: gpio_word_assembler

Overview:
- Sits directly downstream of toggle_to_strobe on the ESP32 GPIO parallel link.
- On each single-cycle strobe, captures one beat from the already-synchronised GPIO data bus.
- Packs BEATS_PER_WORD beats LSB-first into a word and buffers completed words in a small FIFO.
- Presents the FIFO head to fabric logic over a valid/ready handshake.

Parameters:
- BEAT_W, 8: width of one GPIO data beat.
- BEATS_PER_WORD, 4: beats per assembled word; must be ≥2.
- FIFO_DEPTH, 4: word buffer depth; must be a power of 2 and ≥2.
- TIMEOUT_CYCLES, 1024: idle cycles before a partial word is discarded (optional feature only).

Ports:
- i_clk, input, 1: system clock.
- i_rst_n, input, 1: reset, asynchronous assert, active-low.
- i_strobe, input, 1: single-cycle beat strobe from toggle_to_strobe.
- i_beat, input, BEAT_W: GPIO data, stable whenever i_strobe is high.
- i_sof, input, 1: start-of-frame; forces beat alignment.
- o_word, output, BEAT_W*BEATS_PER_WORD: FIFO head word; beat 0 in the LSBs.
- o_valid, output, 1: o_word holds a valid word.
- i_ready, input, 1: consumer accepts o_word when o_valid && i_ready.
- o_level, output, clog2(FIFO_DEPTH)+1: number of words held.
- o_overflow, output, 1: sticky flag; a completed word was dropped.
- o_timeout, output, 1: sticky flag; a partial word was discarded by timeout (0 when the feature is compiled out).
- i_clear_flags, input, 1: clears the sticky flags.

Behaviour:
- Reset (i_rst_n low, asynchronous):
  - Beat counter, shift register, FIFO pointers and flags go to 0.
  - o_word=0, o_valid=0, o_level=0.
- Beat capture:
  - On i_strobe, i_beat is written into slot cnt of the assembly register, then cnt increments.
  - When cnt==BEATS_PER_WORD-1, the completed word (including the current beat) is pushed and cnt wraps to 0.
- Latency: o_valid rises the cycle after the strobe that completes a word, provided the FIFO was empty.
- i_sof rules:
  - i_sof with i_strobe: any partial word is discarded; i_beat goes to slot 0; cnt=1.
  - i_sof without i_strobe: cnt=0, partial word discarded.
  - Neither case sets a flag.
- FIFO and handshake:
  - A pop occurs when o_valid && i_ready.
  - o_word/o_valid come straight from the FIFO head (first-word-fall-through).
  - o_word is held stable while o_valid && !i_ready.
- Full FIFO:
  - A push with no pop in the same cycle is dropped and sets o_overflow.
  - A push with a simultaneous pop is accepted and o_level is unchanged.
- Empty FIFO: a pop cannot occur because o_valid=0; i_ready is don't-care.
- Simultaneous push and pop at any level: o_level is unchanged.
- Flags:
  - Setting and clearing in the same cycle: set wins.
  - The flag stays 1 until an i_clear_flags cycle with no new set event.
- Pointer widths: clog2(FIFO_DEPTH)+1 bits; wrap is natural modulo; full when MSBs differ and LSBs are equal.
- Reset mid-word or mid-handshake: everything is lost; no partial word survives.

Optional Feature:
- Macro: GPIO_WORD_ASSEMBLER_TIMEOUT_EN.
- Defined:
  - An idle counter resets on every i_strobe or i_sof.
  - It increments only while cnt!=0.
  - On reaching TIMEOUT_CYCLES-1, cnt is forced to 0 and o_timeout is set.
  - The idle counter saturates and clears itself afterwards.
- Undefined: no idle counter; partial words persist indefinitely; o_timeout is tied to 0.

Decomposition:
- Package gpio_link_pkg holds:
  - Default BEAT_W and BEATS_PER_WORD.
  - WORD_W = BEAT_W*BEATS_PER_WORD.
  - A clog2-based pointer width function.
- Sub-module gpio_word_fifo: first-word-fall-through sync FIFO, parameterised by width and depth, with push/pop/full/empty/level. It shares the i_clk/i_rst_n conventions.
- The assembler holds the beat counter, assembly register, flags and the optional timeout.

Test Plan:
- Basic assembly: strobes with beats 0x11, 0x22, 0x33, 0x44, i_ready=1 -> o_valid pulses once, one cycle after the 4th strobe, with o_word=0x44332211; o_level returns to 0.
- Backpressure: i_ready=0; send 5 words (20 strobes) -> o_level=4, o_overflow=1, the 5th word is lost. Raise i_ready -> the first 4 words emerge in order, each held until accepted.
- Full boundary: FIFO full, and the completing strobe coincides with a pop -> the word is accepted, o_level stays 4, o_overflow stays 0.
- Realignment: 2 strobes (0xAA, 0xBB), then i_sof+strobe 0x01, then strobes 0x02, 0x03, 0x04 -> single word 0x04030201, no flags.
- Reset mid-operation: 3 beats in, then i_rst_n low for 1 cycle mid-word -> o_valid=0, o_level=0. The next 4 beats form a clean word.
- Timeout (macro defined, TIMEOUT_CYCLES=16): 1 strobe, then 16 idle cycles -> o_timeout=1 and the partial word is discarded. Next 4 beats form a clean word. i_clear_flags -> o_timeout=0.

Source files
------------

// File: rtl/gpio_link_pkg.sv
// ============================================================================
//  Module      : gpio_link_pkg
//  Description : Shared defaults and helpers for the ESP32 GPIO parallel link
//                (beat/word geometry and FIFO pointer sizing).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package gpio_link_pkg;

  localparam int DEF_BEAT_W         = 8;
  localparam int DEF_BEATS_PER_WORD = 4;
  localparam int WORD_W             = DEF_BEAT_W * DEF_BEATS_PER_WORD;

  // Pointer width for a power-of-2 FIFO: one extra bit separates full from empty
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/gpio_word_assembler_if.sv
// ============================================================================
//  Module      : gpio_word_assembler_if
//  Description : Valid/ready word stream from the assembler to fabric logic.
//                master = word producer, slave = word consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface gpio_word_assembler_if
  import gpio_link_pkg::*;
#(
  parameter int WORD_W = gpio_link_pkg::WORD_W
) ();

  logic [WORD_W-1:0] o_word;
  logic              o_valid;
  logic              i_ready;

  modport master (output o_word, output o_valid, input  i_ready);
  modport slave  (input  o_word, input  o_valid, output i_ready);

endinterface

`default_nettype wire

// File: rtl/gpio_word_fifo.sv
// ============================================================================
//  Module      : gpio_word_fifo
//  Description : First-word-fall-through synchronous FIFO. The head entry is
//                visible on o_data whenever the FIFO is not empty. A push into
//                a full FIFO is accepted only when a pop happens in the same
//                cycle. Pointers carry one extra wrap bit.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_word_fifo
  import gpio_link_pkg::*;
#(
  parameter int WIDTH = gpio_link_pkg::WORD_W,
  parameter int DEPTH = 4
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_push,
  input  logic [WIDTH-1:0]        i_data,
  input  logic                    i_pop,
  output logic [WIDTH-1:0]        o_data,
  output logic                    o_full,
  output logic                    o_empty,
  output logic [ptr_w(DEPTH)-1:0] o_level
);

  localparam int AW    = $clog2(DEPTH);
  localparam int PTR_W = ptr_w(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic             pop_ok;
  logic             push_ok;

  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign o_level = wr_ptr_q - rd_ptr_q;

  // Head is masked while empty so the output reads zero after reset
  assign o_data  = o_empty ? '0 : mem_q[rd_ptr_q[AW-1:0]];

  // A pop frees the head slot this cycle, so a push into a full FIFO can land
  always_comb begin
    pop_ok   = i_pop && !o_empty;
    push_ok  = i_push && (!o_full || pop_ok);
    wr_ptr_d = wr_ptr_q + PTR_W'(push_ok);
    rd_ptr_d = rd_ptr_q + PTR_W'(pop_ok);
  end

  // Pointer registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage array; contents are don't-care until written
  always_ff @(posedge i_clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q[AW-1:0]] <= i_data;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpio_word_assembler.sv
// ============================================================================
//  Module      : gpio_word_assembler
//  Description : Packs BEATS_PER_WORD strobed GPIO beats LSB-first into a word,
//                buffers completed words in a FWFT FIFO and presents the head
//                over valid/ready. i_sof realigns the beat counter. Sticky
//                flags report dropped words and timed-out partial words.
//  Options     : GPIO_WORD_ASSEMBLER_TIMEOUT_EN - enables the idle timeout that
//                discards a stalled partial word (TIMEOUT_CYCLES parameter).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module gpio_word_assembler
  import gpio_link_pkg::*;
#(
  parameter int BEAT_W         = DEF_BEAT_W,
  parameter int BEATS_PER_WORD = DEF_BEATS_PER_WORD,
  parameter int FIFO_DEPTH     = 4
`ifdef GPIO_WORD_ASSEMBLER_TIMEOUT_EN
  ,
  parameter int TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_strobe,
  input  logic [BEAT_W-1:0]            i_beat,
  input  logic                         i_sof,
  gpio_word_assembler_if.master        bus,
  output logic [ptr_w(FIFO_DEPTH)-1:0] o_level,
  output logic                         o_overflow,
  output logic                         o_timeout,
  input  logic                         i_clear_flags
);

  localparam int ASM_W = BEAT_W * BEATS_PER_WORD;
  localparam int CNT_W = $clog2(BEATS_PER_WORD);
  localparam logic [CNT_W-1:0] LAST_SLOT = CNT_W'(BEATS_PER_WORD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ASM_W-1:0] asm_q, asm_d;
  logic             overflow_q, overflow_d;
  logic [ASM_W-1:0] push_word;
  logic             push;
  logic             ovf_evt;
  logic             to_fire;
  logic             fifo_full;
  logic             fifo_empty;
  logic [ASM_W-1:0] fifo_head;

`ifdef GPIO_WORD_ASSEMBLER_TIMEOUT_EN
  localparam int IDLE_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [IDLE_W-1:0] idle_q, idle_d;
  logic              timeout_q, timeout_d;

  // Idle counter runs only while a partial word is pending; fires once and clears
  always_comb begin
    idle_d  = '0;
    to_fire = 1'b0;
    if (!(i_strobe || i_sof) && (cnt_q != '0)) begin
      if (idle_q == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
        to_fire = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end
    timeout_d = (timeout_q && !i_clear_flags) || to_fire;
  end

  // Timeout state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      idle_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      idle_q    <= idle_d;
      timeout_q <= timeout_d;
    end
  end

  assign o_timeout = timeout_q;
`else
  assign to_fire   = 1'b0;
  assign o_timeout = 1'b0;
`endif

  // Beat capture, word completion and i_sof realignment
  always_comb begin
    cnt_d     = cnt_q;
    asm_d     = asm_q;
    push      = 1'b0;
    push_word = asm_q;
    for (int b = 0; b < BEATS_PER_WORD; b++) begin
      if (cnt_q == CNT_W'(b)) begin
        push_word[b*BEAT_W +: BEAT_W] = i_beat;
      end
    end
    if (i_strobe) begin
      if (i_sof) begin
        // Start of frame: the strobed beat becomes slot 0 of a fresh word
        asm_d               = '0;
        asm_d[BEAT_W-1:0]   = i_beat;
        cnt_d               = CNT_W'(1);
      end else if (cnt_q == LAST_SLOT) begin
        push  = 1'b1;
        cnt_d = '0;
        asm_d = '0;
      end else begin
        asm_d = push_word;
        cnt_d = cnt_q + 1'b1;
      end
    end else if (i_sof || to_fire) begin
      cnt_d = '0;
      asm_d = '0;
    end
  end

  // A completed word is lost only when the FIFO is full and nothing leaves
  always_comb begin
    ovf_evt    = push && fifo_full && !(bus.i_ready && !fifo_empty);
    overflow_d = (overflow_q && !i_clear_flags) || ovf_evt;
  end

  // Assembler state registers
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      cnt_q      <= '0;
      asm_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_d;
    end
  end

  gpio_word_fifo #(
    .WIDTH (ASM_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (push),
    .i_data  (push_word),
    .i_pop   (bus.i_ready),
    .o_data  (fifo_head),
    .o_full  (fifo_full),
    .o_empty (fifo_empty),
    .o_level (o_level)
  );

  assign bus.o_word  = fifo_head;
  assign bus.o_valid = !fifo_empty;
  assign o_overflow  = overflow_q;

endmodule

`default_nettype wire

// File: tb/tb_gpio_word_assembler.sv
// ============================================================================
//  Module      : tb_gpio_word_assembler
//  Description : Directed self-checking bench for gpio_word_assembler
//                (BEAT_W=8, BEATS_PER_WORD=4, FIFO_DEPTH=4; TIMEOUT_CYCLES=16
//                when GPIO_WORD_ASSEMBLER_TIMEOUT_EN is defined).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_gpio_word_assembler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       strobe;
  logic       sof;
  logic       clear;
  logic [7:0] beat;
  logic [2:0] level;
  logic       ovf;
  logic       tmo;

  int n_checks = 0;
  int n_pass   = 0;

  gpio_word_assembler_if #(.WORD_W(32)) bus ();

  gpio_word_assembler #(
    .BEAT_W         (8),
    .BEATS_PER_WORD (4),
    .FIFO_DEPTH     (4)
`ifdef GPIO_WORD_ASSEMBLER_TIMEOUT_EN
    ,
    .TIMEOUT_CYCLES (16)
`endif
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_strobe      (strobe),
    .i_beat        (beat),
    .i_sof         (sof),
    .bus           (bus.master),
    .o_level       (level),
    .o_overflow    (ovf),
    .o_timeout     (tmo),
    .i_clear_flags (clear)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are then sampled 1 ns after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic s);
    strobe = 1'b1;
    beat   = b;
    sof    = s;
    tick();
    strobe = 1'b0;
    sof    = 1'b0;
  endtask

  // Word k is built from beats 16*k+1 .. 16*k+4, e.g. k=0 -> 0x04030201
  function automatic logic [31:0] mk_word(input int k);
    logic [31:0] w;
    for (int j = 0; j < 4; j++) w[j*8 +: 8] = 8'(16*k + j + 1);
    return w;
  endfunction

  task automatic send_word(input int k);
    for (int j = 0; j < 4; j++) send(8'(16*k + j + 1), 1'b0);
  endtask

  task automatic pop_one();
    bus.i_ready = 1'b1;
    tick();
    bus.i_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000 ns");
    $fatal(1, "bench stalled");
  end

  initial begin
    rst_n = 1'b0; strobe = 1'b0; sof = 1'b0; clear = 1'b0; beat = 8'h00;
    bus.i_ready = 1'b0;
    repeat (3) tick();
    check("rst_word",  bus.o_word,        32'h0);
    check("rst_valid", 32'(bus.o_valid),  32'h0);
    check("rst_level", 32'(level),        32'h0);
    check("rst_ovf",   32'(ovf),          32'h0);
    check("rst_tmo",   32'(tmo),          32'h0);
    rst_n = 1'b1;
    tick();

    // Basic assembly with consumer always ready
    bus.i_ready = 1'b1;
    send(8'h11, 1'b0); send(8'h22, 1'b0); send(8'h33, 1'b0);
    check("basic_novalid", 32'(bus.o_valid), 32'h0);
    send(8'h44, 1'b0);
    check("basic_valid", 32'(bus.o_valid), 32'h1);
    check("basic_word",  bus.o_word,       32'h44332211);
    tick();
    check("basic_pulse", 32'(bus.o_valid), 32'h0);
    check("basic_level", 32'(level),       32'h0);
    bus.i_ready = 1'b0;

    // Backpressure: five words into a four-deep FIFO
    for (int k = 0; k < 4; k++) send_word(k);
    check("bp_level4",   32'(level), 32'h4);
    check("bp_noovf",    32'(ovf),   32'h0);
    send_word(4);
    check("bp_level_ovf", 32'(level), 32'h4);
    check("bp_ovf",       32'(ovf),   32'h1);
    repeat (2) tick();
    check("bp_hold_word",  bus.o_word,       32'h04030201);
    check("bp_hold_valid", 32'(bus.o_valid), 32'h1);
    bus.i_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("bp_drain%0d", k), bus.o_word, mk_word(k));
      tick();
    end
    bus.i_ready = 1'b0;
    check("bp_empty_valid", 32'(bus.o_valid), 32'h0);
    check("bp_empty_level", 32'(level),       32'h0);
    check("bp_ovf_sticky",  32'(ovf),         32'h1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("bp_ovf_clear", 32'(ovf), 32'h0);

    // Full boundary: completing strobe coincides with a pop
    for (int k = 5; k < 9; k++) send_word(k);
    check("full_level", 32'(level), 32'h4);
    send(8'h91, 1'b0); send(8'h92, 1'b0); send(8'h93, 1'b0);
    bus.i_ready = 1'b1;
    send(8'h94, 1'b0);
    check("full_level_same", 32'(level), 32'h4);
    check("full_noovf",      32'(ovf),   32'h0);
    for (int k = 6; k < 10; k++) begin
      check($sformatf("full_drain%0d", k), bus.o_word, mk_word(k));
      tick();
    end
    bus.i_ready = 1'b0;
    check("full_empty", 32'(level), 32'h0);

    // Realignment with i_sof on a strobe
    send(8'hAA, 1'b0); send(8'hBB, 1'b0);
    send(8'h01, 1'b1);
    send(8'h02, 1'b0); send(8'h03, 1'b0); send(8'h04, 1'b0);
    check("sof_level", 32'(level), 32'h1);
    check("sof_word",  bus.o_word, 32'h04030201);
    check("sof_ovf",   32'(ovf),   32'h0);
    check("sof_tmo",   32'(tmo),   32'h0);
    pop_one();

    // i_sof alone discards the pending partial word
    send(8'h55, 1'b0);
    sof = 1'b1; tick(); sof = 1'b0;
    send(8'h61, 1'b0); send(8'h62, 1'b0); send(8'h63, 1'b0); send(8'h64, 1'b0);
    check("sofonly_level", 32'(level), 32'h1);
    check("sofonly_word",  bus.o_word, 32'h64636261);
    pop_one();

`ifdef GPIO_WORD_ASSEMBLER_TIMEOUT_EN
    // One beat, then idle: discarded on the 16th idle cycle
    send(8'hEE, 1'b0);
    repeat (15) tick();
    check("to_not_yet", 32'(tmo), 32'h0);
    tick();
    check("to_fired", 32'(tmo), 32'h1);
    send(8'hE1, 1'b0); send(8'hE2, 1'b0); send(8'hE3, 1'b0); send(8'hE4, 1'b0);
    check("to_level", 32'(level), 32'h1);
    check("to_word",  bus.o_word, 32'hE4E3E2E1);
    pop_one();
    check("to_sticky", 32'(tmo), 32'h1);
    clear = 1'b1; tick(); clear = 1'b0;
    check("to_clear", 32'(tmo), 32'h0);
`else
    // Without the timeout a partial word survives any idle time
    send(8'hE1, 1'b0);
    repeat (20) tick();
    check("noto_tmo", 32'(tmo), 32'h0);
    send(8'hE2, 1'b0); send(8'hE3, 1'b0); send(8'hE4, 1'b0);
    check("noto_level", 32'(level), 32'h1);
    check("noto_word",  bus.o_word, 32'hE4E3E2E1);
    pop_one();
`endif

    // Asynchronous reset in the middle of a word with a word queued
    send_word(1);
    send(8'hD1, 1'b0); send(8'hD2, 1'b0); send(8'hD3, 1'b0);
    check("mid_level_pre", 32'(level), 32'h1);
    rst_n = 1'b0;
    #2;
    check("mid_valid", 32'(bus.o_valid), 32'h0);
    check("mid_level", 32'(level),       32'h0);
    tick();
    rst_n = 1'b1;
    tick();
    send(8'hC1, 1'b0); send(8'hC2, 1'b0); send(8'hC3, 1'b0); send(8'hC4, 1'b0);
    check("post_level", 32'(level), 32'h1);
    check("post_word",  bus.o_word, 32'hC4C3C2C1);
    check("post_ovf",   32'(ovf),   32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

`default_nettype wire
